// File: rtl/sect409r1_pt_check_if.sv
// Request/response bundle for the sect409r1 point-on-curve checker.
interface sect409r1_pt_check_if #(
    parameter int M = 409
);
    logic         clr;
    logic         start;
    logic [M-1:0] x;
    logic [M-1:0] y;
    logic         done;
    logic         valid;

    modport master (
        output clr, start, x, y,
        input  done, valid
    );

    modport slave (
        input  clr, start, x, y,
        output done, valid
    );
endinterface

// File: rtl/sect409r1_pt_check.sv
// Checks y^2 + xy == x^3 + x^2 + b over GF(2^M) using three products computed
// one after another on a single bit-serial MSB-first multiplier.
module sect409r1_pt_check #(
    parameter int           M  = 409,
    parameter logic [M-1:0] FX = 409'h8000000000000000000001,
    parameter logic [M-1:0] B  = 409'h21a5c2c8ee9feb5c4b9a753b7b476b7fd6422ef1f3dd674761fa99d6ac27c8a9a197b272822f6cd57a55aa4f50ae317b13545f
) (
    input  logic                clk,
    input  logic                rst_n,
    sect409r1_pt_check_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE,
        MUL1,
        MUL2,
        MUL3,
        CHK
    } state_e;

    localparam int            CW   = 9;
    localparam logic [CW-1:0] LAST = CW'(M - 1);

    state_e        state_q;
    logic [CW-1:0] cnt_q;
    logic [M-1:0]  x_q, y_q, acc_q;
    logic [M-1:0]  m1_q, m2_q, m3_q;
    logic          done_q, valid_q;

    logic [M-1:0]  op_a, op_b, acc_d;
    logic [CW-1:0] bit_idx;

    // Operand routing: m1 = x*x, m2 = m1*(x+1), m3 = y*(y+x).
    always_comb begin
        // NOTE: defaults first so every path assigns the outputs and no latch is inferred.
        op_a = '0;
        op_b = '0;
        case (state_q)
            MUL1: begin
                op_a = x_q;
                op_b = x_q;
            end
            MUL2: begin
                op_a = m1_q;
                op_b = {x_q[M-1:1], ~x_q[0]};
            end
            MUL3: begin
                op_a = y_q;
                op_b = y_q ^ x_q;
            end
            default: ;
        endcase
    end

    assign bit_idx = LAST - cnt_q;
    assign acc_d   = {acc_q[M-2:0], 1'b0} ^ (acc_q[M-1] ? FX : '0)
                   ^ (op_b[bit_idx] ? op_a : '0);

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            acc_q   <= '0;
            m1_q    <= '0;
            m2_q    <= '0;
            m3_q    <= '0;
            done_q  <= 1'b0;
            valid_q <= 1'b0;
        end else if (bus.clr) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            done_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        x_q     <= bus.x;
                        y_q     <= bus.y;
                        acc_q   <= '0;
                        cnt_q   <= '0;
                        state_q <= MUL1;
                    end
                end
                MUL1, MUL2, MUL3: begin
                    if (cnt_q == LAST) begin
                        acc_q <= '0;
                        cnt_q <= '0;
                        case (state_q)
                            MUL1: begin
                                m1_q    <= acc_d;
                                state_q <= MUL2;
                            end
                            MUL2: begin
                                m2_q    <= acc_d;
                                state_q <= MUL3;
                            end
                            default: begin
                                m3_q    <= acc_d;
                                state_q <= CHK;
                            end
                        endcase
                    end else begin
                        acc_q <= acc_d;
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                CHK: begin
                    valid_q <= ((m2_q ^ m3_q ^ B) == '0);
                    done_q  <= 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.done  = done_q;
    assign bus.valid = valid_q;

endmodule

// File: tb/tb_sect409r1_pt_check.sv
// Bench for the sect409r1 on-curve checker: vector table, random pairs against
// a field/point model, and abort/ignore sequences.
module tb_sect409r1_pt_check;

    localparam int M   = 409;
    localparam int PW  = 2 * M - 1;
    localparam int LAT = 3 * M + 1;

    typedef logic [M-1:0] fe_t;

    localparam fe_t FX = 409'h8000000000000000000001;
    localparam fe_t B  = 409'h21a5c2c8ee9feb5c4b9a753b7b476b7fd6422ef1f3dd674761fa99d6ac27c8a9a197b272822f6cd57a55aa4f50ae317b13545f;
    localparam fe_t XG = 409'h15d4860d088ddb3496b0c6064756260441cde4af1771d4db01ffe5b34e59703dc255a868a1180515603aeab60794e54bb7996a7;
    localparam fe_t YG = 409'h61b1cfab6be5f32bbfa78324ed106a7636b9c5a7bd198d0158aa4f5488d08f38514f1fdf4b4f40d2181b3681c364ba0273c706;

    typedef struct {
        fe_t  x;
        fe_t  y;
        logic exp_v;
    } vec_t;

    vec_t  vecs[$];
    string names[$];

    logic clk = 1'b0;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;

    sect409r1_pt_check_if #(.M(M)) bus();

    sect409r1_pt_check dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Field model: full carry-less product, then reduction by f(x).
    function automatic fe_t gf_mul(input fe_t a, input fe_t b);
        logic [PW-1:0] p;
        p = '0;
        for (int i = 0; i < M; i++)
            if (b[i]) p ^= PW'(a) << i;
        for (int i = PW - 1; i >= M; i--)
            if (p[i]) p ^= PW'({1'b1, FX}) << (i - M);
        return p[M-1:0];
    endfunction

    // a^(2^M - 2)
    function automatic fe_t gf_inv(input fe_t a);
        fe_t r;
        r = a;
        for (int i = 0; i < M - 2; i++) r = gf_mul(gf_mul(r, r), a);
        return gf_mul(r, r);
    endfunction

    function automatic logic on_curve(input fe_t x, input fe_t y);
        fe_t lhs, rhs;
        lhs = gf_mul(y, y) ^ gf_mul(x, y);
        rhs = gf_mul(gf_mul(x, x), x) ^ gf_mul(x, x) ^ B;
        return lhs == rhs;
    endfunction

    function automatic void pt_dbl(input fe_t x1, input fe_t y1, output fe_t x3, output fe_t y3);
        fe_t lam;
        lam = x1 ^ gf_mul(y1, gf_inv(x1));
        x3  = gf_mul(lam, lam) ^ lam ^ fe_t'(1);
        y3  = gf_mul(x1, x1) ^ gf_mul(lam ^ fe_t'(1), x3);
    endfunction

    function automatic void pt_add(input fe_t x1, input fe_t y1, input fe_t x2, input fe_t y2,
                                   output fe_t x3, output fe_t y3);
        fe_t lam;
        lam = gf_mul(y1 ^ y2, gf_inv(x1 ^ x2));
        x3  = gf_mul(lam, lam) ^ lam ^ x1 ^ x2 ^ fe_t'(1);
        y3  = gf_mul(lam, x1 ^ x3) ^ x3 ^ y1;
    endfunction

    function automatic fe_t rand_fe();
        fe_t v;
        v = '0;
        for (int i = 0; i < 13; i++) v = {v[M-33:0], $urandom()};
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic add_vec(input string name, input fe_t vx, input fe_t vy, input logic ev);
        vec_t v;
        v.x   = vx;
        v.y   = vy;
        v.exp_v = ev;
        vecs.push_back(v);
        names.push_back(name);
    endtask

    // Returns the number of edges until done is seen, or -1 past the limit.
    task automatic wait_done(input int limit, output int n);
        n = -1;
        for (int k = 1; k <= limit && n < 0; k++) begin
            @(negedge clk);
            if (bus.done === 1'b1) n = k;
        end
    endtask

    task automatic count_done(input int ncyc, output int pulses);
        pulses = 0;
        for (int k = 0; k < ncyc; k++) begin
            @(negedge clk);
            if (bus.done !== 1'b0) pulses++;
        end
    endtask

    task automatic issue(input fe_t vx, input fe_t vy);
        @(negedge clk);
        bus.x     = vx;
        bus.y     = vy;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.x     = rand_fe();
        bus.y     = rand_fe();
    endtask

    task automatic run_vec(input string name, input fe_t vx, input fe_t vy, input logic exp_v);
        int n;
        issue(vx, vy);
        wait_done(LAT + 20, n);
        check({name, " latency"}, n, LAT);
        check({name, " valid"}, {31'd0, bus.valid}, {31'd0, exp_v});
        @(negedge clk);
        check({name, " done width"}, {31'd0, bus.done}, 32'd0);
    endtask

    initial begin
        fe_t x2, y2, x3, y3, sb, rx, ry;
        int  n, p;

        pt_dbl(XG, YG, x2, y2);
        pt_add(x2, y2, XG, YG, x3, y3);
        sb = B;
        for (int i = 0; i < M - 1; i++) sb = gf_mul(sb, sb);

        add_vec("G",          XG, YG,           1'b1);
        add_vec("G y^1",      XG, YG ^ fe_t'(1), 1'b0);
        add_vec("zero",       '0, '0,           1'b0);
        add_vec("2G",         x2, y2,           1'b1);
        add_vec("3G",         x3, y3,           1'b1);
        add_vec("(n-1)G",     XG, XG ^ YG,      1'b1);
        add_vec("x0 sqrt b",  '0, sb,           1'b1);
        add_vec("x0 y1",      '0, fe_t'(1),     1'b0);
        add_vec("all ones",   '1, '1,           on_curve('1, '1));

        bus.clr   = 1'b0;
        bus.start = 1'b0;
        bus.x     = '0;
        bus.y     = '0;
        rst_n     = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        check("reset done", {31'd0, bus.done}, 32'd0);
        check("reset valid", {31'd0, bus.valid}, 32'd0);

        for (int i = 0; i < vecs.size(); i++)
            run_vec(names[i], vecs[i].x, vecs[i].y, vecs[i].exp_v);

        for (int i = 0; i < 4; i++) begin
            rx = rand_fe();
            ry = rand_fe();
            run_vec($sformatf("random %0d", i), rx, ry, on_curve(rx, ry));
        end

        // Second start 500 edges in must be ignored.
        issue(XG, YG);
        repeat (499) @(negedge clk);
        bus.x     = rand_fe();
        bus.y     = rand_fe();
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done(LAT, n);
        check("busy start latency", n, LAT - 500);
        check("busy start valid", {31'd0, bus.valid}, 32'd1);
        count_done(60, p);
        check("busy start single done", p, 0);

        // Reset pulse during MUL2 aborts the check.
        issue(XG, YG);
        repeat (M + 100) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("mid reset done", {31'd0, bus.done}, 32'd0);
        check("mid reset valid", {31'd0, bus.valid}, 32'd0);
        count_done(LAT, p);
        check("mid reset no done", p, 0);

        // Start while reset is held is not accepted.
        @(negedge clk);
        rst_n     = 1'b0;
        bus.x     = XG;
        bus.y     = YG;
        bus.start = 1'b1;
        @(negedge clk);
        rst_n     = 1'b1;
        bus.start = 1'b0;
        count_done(LAT + 10, p);
        check("start in reset ignored", p, 0);
        run_vec("after reset", XG, YG, 1'b1);

        // clr 800 edges in aborts the check.
        issue(XG, XG ^ YG);
        repeat (799) @(negedge clk);
        bus.clr = 1'b1;
        @(negedge clk);
        bus.clr = 1'b0;
        check("clr valid", {31'd0, bus.valid}, 32'd0);
        count_done(LAT, p);
        check("clr no done", p, 0);
        run_vec("after clr", XG, YG, 1'b1);

        // clr overrides start on the same edge.
        @(negedge clk);
        bus.x     = XG;
        bus.y     = YG;
        bus.start = 1'b1;
        bus.clr   = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.clr   = 1'b0;
        check("clr+start valid", {31'd0, bus.valid}, 32'd0);
        count_done(LAT + 10, p);
        check("clr+start no done", p, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
